// File: rtl/ex_sequencer.sv
// ---------------------------------------------------------------------------
// ex_sequencer
//   Execute-stage control sequencer. Takes one decoded instruction at a time
//   from ID over a valid/ready handshake, drives the registered operand select
//   and control code to a clocked ALU, and waits ALU_LAT cycles. It then
//   latches the zero/overflow flags, resolves BEQ/BNE, and offers the result
//   to MEM over a second valid/ready handshake. A taken branch flushes ID for
//   one cycle.
//
// Parameters
//   ALU_LAT        ALU result latency in clocks (1..15)
//
// Configuration
//   EX_PERF_CNT_EN when defined, adds a 32-bit stall counter output
//                  (stall_cnt) that counts cycles with in_valid & ~in_ready
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_valid/ready  ID -> EX handshake
//   in_alu_src      1 = immediate operand, 0 = rs2
//   in_alu_func     ALU control code
//   in_branch       conditional branch flag
//   in_br_type      funct3 (000 = BEQ, 001 = BNE)
//   in_rd           destination register
//   in_reg_write    instruction writes rd
//   alu_src/func    registered controls to the ALU
//   alu_zero        ALU zero flag
//   alu_overflow    ALU overflow flag
//   out_valid/ready EX -> MEM handshake
//   out_rd          destination register
//   out_reg_write   write enable, suppressed on an overflow trap
//   branch_taken    branch resolved taken (valid with out_valid)
//   flush           one-cycle kill of the wrong-path fetch/ID
//   ovf_trap        overflow trap (valid with out_valid)
//   stall_cnt       ID stall cycle count (EX_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module ex_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_alu_src,
  input  logic [3:0]  in_alu_func,
  input  logic        in_branch,
  input  logic [2:0]  in_br_type,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        alu_src,
  output logic [3:0]  alu_func,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        branch_taken,
  output logic        flush,
  output logic        ovf_trap
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_alu_src;
  logic [3:0]  r_alu_func;
  logic        r_branch;
  logic [2:0]  r_br_type;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic [4:0]  r_out_rd;
  logic        r_out_reg_write;
  logic        r_taken;
  logic        r_ovf;

  logic        w_done;
  logic        w_handshake;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_taken;
  logic        w_ovf;

  assign w_done      = (r_state == DONE);
  assign w_handshake = w_done & out_ready;

  // A completing not-taken result frees the stage in the same cycle, so ID
  // may hand over the next instruction back-to-back. A taken branch never
  // accepts in its handshake cycle: that instruction is the wrong path.
  assign w_in_ready  = (r_state == IDLE) | (w_handshake & ~r_taken);
  assign w_accept    = in_valid & w_in_ready;

  // Branch resolution uses the flags as they arrive at the end of EXEC.
  assign w_taken = r_branch & (((r_br_type == 3'b000) &  alu_zero) |
                               ((r_br_type == 3'b001) & ~alu_zero));
  assign w_ovf   = alu_overflow & ~r_branch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_cnt           <= 4'd0;
      r_alu_src       <= 1'b0;
      r_alu_func      <= 4'h0;
      r_branch        <= 1'b0;
      r_br_type       <= 3'b000;
      r_rd            <= 5'd0;
      r_reg_write     <= 1'b0;
      r_out_rd        <= 5'd0;
      r_out_reg_write <= 1'b0;
      r_taken         <= 1'b0;
      r_ovf           <= 1'b0;
    end else begin
      // Capture happens from IDLE or from a not-taken DONE handshake; the
      // ALU controls stay put until the next capture.
      if (w_accept) begin
        r_alu_src   <= in_alu_src;
        r_alu_func  <= in_alu_func;
        r_branch    <= in_branch;
        r_br_type   <= in_br_type;
        r_rd        <= in_rd;
        r_reg_write <= in_reg_write;
        r_cnt       <= 4'(ALU_LAT - 1);
      end

      unique case (r_state)
        IDLE: begin
          if (in_valid) r_state <= EXEC;
        end
        EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_taken         <= w_taken;
            r_ovf           <= w_ovf;
            r_out_rd        <= r_rd;
            r_out_reg_write <= r_reg_write & ~w_ovf;
            r_state         <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= w_accept ? EXEC : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready      = w_in_ready;
  assign alu_src       = r_alu_src;
  assign alu_func      = r_alu_func;
  assign out_valid     = w_done;
  assign out_rd        = r_out_rd;
  assign out_reg_write = r_out_reg_write;
  assign branch_taken  = r_taken;
  assign ovf_trap      = r_ovf;
  assign flush         = w_handshake & r_taken;

`ifdef EX_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  // Free-running count of cycles where ID is held off; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stall_cnt <= 32'd0;
    else if (in_valid & ~w_in_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ex_sequencer
//   Drives two sequencers (ALU_LAT = 1 and ALU_LAT = 3) with directed and
//   random instruction streams and compares every output each cycle against
//   a transaction-level reference: an instruction accepted in cycle c shows
//   out_valid from cycle c+LAT+1 until MEM takes it, with the result computed
//   from the branch/overflow rules and the flags present in cycle c+LAT.
// ---------------------------------------------------------------------------
module tb_ex_sequencer;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       inValid    [2];
  logic       inReady    [2];
  logic       inAluSrc   [2];
  logic [3:0] inAluFunc  [2];
  logic       inBranch   [2];
  logic [2:0] inBrType   [2];
  logic [4:0] inRd       [2];
  logic       inRegWrite [2];
  logic       aluSrc     [2];
  logic [3:0] aluFunc    [2];
  logic       aluZero    [2];
  logic       aluOvf     [2];
  logic       outValid   [2];
  logic       outReady   [2];
  logic [4:0] outRd      [2];
  logic       outRegWrite[2];
  logic       brTaken    [2];
  logic       flush      [2];
  logic       ovfTrap    [2];
`ifdef EX_PERF_CNT_EN
  logic [31:0] stallCnt  [2];
`endif

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model state per instance
  bit         mBusy   [2];
  int         mAcc    [2];
  bit         tBr     [2];
  bit [2:0]   tBt     [2];
  bit [4:0]   tRd     [2];
  bit         tRw     [2];
  bit         tZero   [2];
  bit         tOvf    [2];
  bit         nZero   [2];
  bit         nOvf    [2];
  bit         mAluSrc [2];
  bit [3:0]   mAluFunc[2];
  int unsigned mStall [2];

  // Clock: 10 time units, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Two DUTs differing only in ALU latency
  for (genvar g = 0; g < 2; g++) begin : gDut
    ex_sequencer #(.ALU_LAT(g == 0 ? LAT0 : LAT1)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (inValid[g]),
      .in_ready     (inReady[g]),
      .in_alu_src   (inAluSrc[g]),
      .in_alu_func  (inAluFunc[g]),
      .in_branch    (inBranch[g]),
      .in_br_type   (inBrType[g]),
      .in_rd        (inRd[g]),
      .in_reg_write (inRegWrite[g]),
      .alu_src      (aluSrc[g]),
      .alu_func     (aluFunc[g]),
      .alu_zero     (aluZero[g]),
      .alu_overflow (aluOvf[g]),
      .out_valid    (outValid[g]),
      .out_ready    (outReady[g]),
      .out_rd       (outRd[g]),
      .out_reg_write(outRegWrite[g]),
      .branch_taken (brTaken[g]),
      .flush        (flush[g]),
      .ovf_trap     (ovfTrap[g])
`ifdef EX_PERF_CNT_EN
      ,
      .stall_cnt    (stallCnt[g])
`endif
    );
  end

  function automatic int latOf(int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  // One comparison: counts it, and reports and counts a failure
  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      mBusy[i]    = 1'b0;
      mAluSrc[i]  = 1'b0;
      mAluFunc[i] = 4'h0;
      mStall[i]   = 0;
    end
  endtask

  task automatic setIdle(int i);
    inValid[i]    = 1'b0;
    inAluSrc[i]   = 1'b0;
    inAluFunc[i]  = 4'h0;
    inBranch[i]   = 1'b0;
    inBrType[i]   = 3'b000;
    inRd[i]       = 5'd0;
    inRegWrite[i] = 1'b0;
    outReady[i]   = 1'b1;
    nZero[i]      = 1'b0;
    nOvf[i]       = 1'b0;
  endtask

  // Compare instance i against the reference, then advance the reference
  // by one cycle using the inputs present in this cycle.
  task automatic checkOutput(int i);
    bit expValid, expTaken, expOvf, expReady, hs;
    expValid = mBusy[i] && (cyc >= mAcc[i] + latOf(i) + 1);
    expTaken = tBr[i] && ((tBt[i] == 3'b000 && tZero[i]) ||
                          (tBt[i] == 3'b001 && !tZero[i]));
    expOvf   = tOvf[i] && !tBr[i];
    hs       = expValid && outReady[i];
    expReady = !mBusy[i] || (hs && !expTaken);

    cmp($sformatf("out_valid[%0d] c%0d", i, cyc), 32'(outValid[i]), 32'(expValid));
    cmp($sformatf("in_ready[%0d] c%0d", i, cyc), 32'(inReady[i]), 32'(expReady));
    cmp($sformatf("flush[%0d] c%0d", i, cyc), 32'(flush[i]), 32'(hs && expTaken));
    cmp($sformatf("alu_src[%0d] c%0d", i, cyc), 32'(aluSrc[i]), 32'(mAluSrc[i]));
    cmp($sformatf("alu_func[%0d] c%0d", i, cyc), 32'(aluFunc[i]), 32'(mAluFunc[i]));
    if (expValid) begin
      cmp($sformatf("out_rd[%0d] c%0d", i, cyc), 32'(outRd[i]), 32'(tRd[i]));
      cmp($sformatf("out_reg_write[%0d] c%0d", i, cyc), 32'(outRegWrite[i]),
          32'(tRw[i] && !expOvf));
      cmp($sformatf("branch_taken[%0d] c%0d", i, cyc), 32'(brTaken[i]), 32'(expTaken));
      cmp($sformatf("ovf_trap[%0d] c%0d", i, cyc), 32'(ovfTrap[i]), 32'(expOvf));
    end
`ifdef EX_PERF_CNT_EN
    cmp($sformatf("stall_cnt[%0d] c%0d", i, cyc), stallCnt[i], 32'(mStall[i]));
`endif

    if (inValid[i] && !expReady) mStall[i]++;
    if (hs) mBusy[i] = 1'b0;
    if (inValid[i] && expReady) begin
      mBusy[i]    = 1'b1;
      mAcc[i]     = cyc;
      tBr[i]      = inBranch[i];
      tBt[i]      = inBrType[i];
      tRd[i]      = inRd[i];
      tRw[i]      = inRegWrite[i];
      tZero[i]    = nZero[i];
      tOvf[i]     = nOvf[i];
      mAluSrc[i]  = inAluSrc[i];
      mAluFunc[i] = inAluFunc[i];
    end
  endtask

  // One clock cycle: entered just after a rising edge. ALU flags carry the
  // instruction's values only in its latch cycle and noise otherwise.
  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      if (mBusy[i] && cyc == mAcc[i] + latOf(i)) begin
        aluZero[i] = tZero[i];
        aluOvf[i]  = tOvf[i];
      end else begin
        aluZero[i] = 1'($urandom);
        aluOvf[i]  = 1'($urandom);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) checkOutput(i);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one cycle of stimulus on instance sel; the other stays idle
  task automatic applyStimulus(int sel, bit v, bit src, bit [3:0] func, bit br,
                               bit [2:0] bt, bit [4:0] rd, bit rw, bit ordy,
                               bit z, bit o);
    setIdle(1 - sel);
    inValid[sel]    = v;
    inAluSrc[sel]   = src;
    inAluFunc[sel]  = func;
    inBranch[sel]   = br;
    inBrType[sel]   = bt;
    inRd[sel]       = rd;
    inRegWrite[sel] = rw;
    outReady[sel]   = ordy;
    nZero[sel]      = z;
    nOvf[sel]       = o;
    tick();
  endtask

  task automatic idleCycles(int sel, int n);
    for (int k = 0; k < n; k++) applyStimulus(sel, 0, 0, 4'h0, 0, 3'b000, 5'd0, 0, 1, 0, 0);
  endtask

  // Asynchronous reset in mid-cycle; entered just after a rising edge
  task automatic doReset();
    setIdle(0);
    setIdle(1);
    rst = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      cmp($sformatf("rst out_valid[%0d]", i), 32'(outValid[i]), 32'd0);
      cmp($sformatf("rst flush[%0d]", i), 32'(flush[i]), 32'd0);
      cmp($sformatf("rst alu_func[%0d]", i), 32'(aluFunc[i]), 32'd0);
      cmp($sformatf("rst alu_src[%0d]", i), 32'(aluSrc[i]), 32'd0);
      cmp($sformatf("rst out_rd[%0d]", i), 32'(outRd[i]), 32'd0);
      cmp($sformatf("rst out_reg_write[%0d]", i), 32'(outRegWrite[i]), 32'd0);
      cmp($sformatf("rst branch_taken[%0d]", i), 32'(brTaken[i]), 32'd0);
      cmp($sformatf("rst ovf_trap[%0d]", i), 32'(ovfTrap[i]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      cmp($sformatf("post-rst in_ready[%0d]", i), 32'(inReady[i]), 32'd1);
    resetModel();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL timeout: observed no finish, expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  // Directed scenarios followed by random traffic on both latencies
  initial begin
`ifdef EX_PERF_CNT_EN
    logic [31:0] s0;
`endif
    setIdle(0);
    setIdle(1);
    aluZero[0] = 1'b0; aluZero[1] = 1'b0;
    aluOvf[0]  = 1'b0; aluOvf[1]  = 1'b0;
    resetModel();
    @(posedge clk);
    #1;
    doReset();

    // ADD, rd=5, write, MEM always ready (ALU_LAT=1)
    applyStimulus(0, 1, 1, 4'h2, 0, 3'b000, 5'd5, 1, 1, 0, 0);
    idleCycles(0, 3);

    // BEQ with zero=1 and the next instruction held valid: flush, no accept
    applyStimulus(0, 1, 0, 4'h6, 1, 3'b000, 5'd0, 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 1, 4'h3, 0, 3'b000, 5'd7, 1, 1, 0, 0);
    idleCycles(0, 3);

    // BNE with zero=1: not taken, back-to-back accept in the handshake cycle
    applyStimulus(0, 1, 0, 4'h6, 1, 3'b001, 5'd0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 4'h4, 0, 3'b000, 5'd9, 1, 1, 0, 0);
    idleCycles(0, 3);

    // ADD with overflow: trap, write suppressed
    applyStimulus(0, 1, 0, 4'h2, 0, 3'b000, 5'd12, 1, 1, 0, 1);
    idleCycles(0, 3);

    // ALU_LAT=3 with MEM stalled 4 cycles and ID holding valid throughout
`ifdef EX_PERF_CNT_EN
    s0 = stallCnt[1];
`endif
    for (int k = 0; k < 8; k++) applyStimulus(1, 1, 1, 4'h2, 0, 3'b000, 5'd21, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 4'h2, 0, 3'b000, 5'd21, 1, 1, 0, 0);
`ifdef EX_PERF_CNT_EN
    cmp("stall_cnt delta", stallCnt[1] - s0, 32'd7);
`endif
    idleCycles(1, 6);

    // Reset while in EXEC drops the instruction
    applyStimulus(1, 1, 1, 4'hA, 0, 3'b000, 5'd3, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 4'h0, 0, 3'b000, 5'd0, 0, 1, 0, 0);
    doReset();
    idleCycles(1, 2);

    // Random traffic on each latency
    for (int sel = 0; sel < 2; sel++) begin
      for (int k = 0; k < 200; k++) begin
        applyStimulus(sel,
                      $urandom_range(0, 3) != 0,
                      1'($urandom),
                      4'($urandom),
                      $urandom_range(0, 2) == 0,
                      3'($urandom_range(0, 3)),
                      5'($urandom),
                      1'($urandom),
                      $urandom_range(0, 9) < 7,
                      1'($urandom),
                      $urandom_range(0, 3) == 0);
      end
      idleCycles(sel, 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
